// File: rtl/iline_responder.sv
// Instruction-fetch responder with a single 256-bit line buffer, filled in 64-bit bursts.
// Optional ILINE_EARLY_RESP_EN: answer as soon as the requested beat lands instead of after beat 3.
module iline_responder #(
    parameter int width      = 32,
    parameter int beat_width = 64,
    parameter int line_beats = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_read,
    input  logic [width-1:0]      i_mem_address,
    output logic                  i_mem_resp,
    output logic [width-1:0]      i_mem_rdata,
    output logic                  pmem_read,
    output logic [width-1:0]      pmem_address,
    input  logic [beat_width-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int cnt_w          = $clog2(line_beats);
    localparam int words_per_beat = beat_width / width;
    localparam int half_w         = $clog2(words_per_beat);
    localparam int offset_w       = 2 + half_w + cnt_w;
    localparam int tag_w          = width - offset_w;
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(line_beats - 1);

    typedef enum logic [1:0] {IDLE, FILL, RESPOND} state_t;

    state_t               state_reg, state_next;
    logic                 valid_reg;
    logic [tag_w-1:0]     tag_reg;
    logic [width-1:0]     req_addr_reg;
    logic [cnt_w-1:0]     beat_cnt_reg;
    logic [width-1:0]     rdata_reg;
`ifdef ILINE_EARLY_RESP_EN
    logic                 early_resp_reg;
`endif

    logic [line_beats-1:0][beat_width-1:0] line_beat;

    logic [tag_w-1:0]  in_tag;
    logic [cnt_w-1:0]  in_beat;
    logic [half_w-1:0] in_half;
    logic [cnt_w-1:0]  req_beat;
    logic [half_w-1:0] req_half;
    logic              hit;
    logic              beat_wr;
    logic              last_wr;
    logic              req_beat_wr;
    logic [width-1:0]  hit_word;
    logic [width-1:0]  fill_word;
    logic              unused_addr_bits;

    function automatic logic [width-1:0] pick_word(input logic [beat_width-1:0] b,
                                                   input logic [half_w-1:0] h);
        return b[h*width +: width];
    endfunction

    assign in_tag   = i_mem_address[width-1:offset_w];
    assign in_beat  = i_mem_address[offset_w-1:2+half_w];
    assign in_half  = i_mem_address[2+half_w-1:2];
    assign req_beat = req_addr_reg[offset_w-1:2+half_w];
    assign req_half = req_addr_reg[2+half_w-1:2];
    assign unused_addr_bits = ^{i_mem_address[1:0], req_addr_reg[1:0]};

    assign hit         = valid_reg && (tag_reg == in_tag);
    assign beat_wr     = (state_reg == FILL) && pmem_resp;
    assign last_wr     = beat_wr && (beat_cnt_reg == last_beat);
    assign req_beat_wr = beat_wr && (beat_cnt_reg == req_beat);

    // The requested beat may be arriving this very cycle, so bypass the buffer for it.
    assign hit_word  = pick_word(line_beat[in_beat], in_half);
    assign fill_word = pick_word((req_beat == beat_cnt_reg) ? pmem_rdata : line_beat[req_beat],
                                 req_half);

    genvar gi;
    generate
        for (gi = 0; gi < line_beats; gi++) begin : g_beat
            logic [beat_width-1:0] beat_reg;
            always_ff @(posedge clk) begin
                if (beat_wr && (beat_cnt_reg == cnt_w'(gi))) begin
                    beat_reg <= pmem_rdata;
                end
            end
            assign line_beat[gi] = beat_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_mem_read) begin
                    state_next = hit ? RESPOND : FILL;
                end
            end
            FILL: begin
                if (last_wr) begin
`ifdef ILINE_EARLY_RESP_EN
                    // An earlier beat already produced the response; just finish the burst.
                    state_next = (req_beat == last_beat) ? RESPOND : IDLE;
`else
                    state_next = RESPOND;
`endif
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            tag_reg      <= '0;
            req_addr_reg <= '0;
            beat_cnt_reg <= '0;
            rdata_reg    <= '0;
`ifdef ILINE_EARLY_RESP_EN
            early_resp_reg <= 1'b0;
`endif
        end else begin
`ifdef ILINE_EARLY_RESP_EN
            early_resp_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (i_mem_read) begin
                        req_addr_reg <= i_mem_address;
                        if (hit) begin
                            rdata_reg <= hit_word;
                        end else begin
                            valid_reg    <= 1'b0;
                            tag_reg      <= in_tag;
                            beat_cnt_reg <= '0;
                        end
                    end
                end
                FILL: begin
                    if (beat_wr) begin
                        beat_cnt_reg <= beat_cnt_reg + cnt_w'(1);
                    end
                    if (last_wr) begin
                        valid_reg <= 1'b1;
                    end
`ifdef ILINE_EARLY_RESP_EN
                    if (req_beat_wr) begin
                        rdata_reg      <= fill_word;
                        early_resp_reg <= (beat_cnt_reg != last_beat);
                    end
`else
                    if (last_wr) begin
                        rdata_reg <= fill_word;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        i_mem_resp   = (state_reg == RESPOND);
`ifdef ILINE_EARLY_RESP_EN
        i_mem_resp   = i_mem_resp || early_resp_reg;
`endif
        pmem_read    = (state_reg == FILL);
        pmem_address = '0;
        if (state_reg == FILL) begin
            pmem_address = {req_addr_reg[width-1:offset_w], {offset_w{1'b0}}};
        end
    end

    assign i_mem_rdata = rdata_reg;

endmodule

// File: tb/tb_iline_responder.sv
// Directed bench for iline_responder: a beat-serving memory model and a response scoreboard.
// Expected latencies follow ILINE_EARLY_RESP_EN when the bench is built with it.
module tb_iline_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_mem_read = 1'b0;
    logic [31:0] i_mem_address = '0;
    logic        i_mem_resp;
    logic [31:0] i_mem_rdata;
    logic        pmem_read;
    logic [31:0] pmem_address;
    logic [63:0] pmem_rdata = '0;
    logic        pmem_resp = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle_cnt    = 0;

    logic [31:0] exp_q[$];

    // Results of the most recent run_req call
    bit          seen_miss;
    logic [31:0] miss_addr;
    int          lat;
    int          resp_cycle;
    int          resp_count;
    bit          pread_dropped;

    iline_responder dut (
        .clk          (clk),
        .rst          (rst),
        .i_mem_read   (i_mem_read),
        .i_mem_address(i_mem_address),
        .i_mem_resp   (i_mem_resp),
        .i_mem_rdata  (i_mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    // Memory contents: word w of line 0x100 is w * 0x11111111, other lines are offset by base-0x100.
    function automatic logic [31:0] word_val(input logic [31:0] base, input int w);
        return 32'h1111_1111 * 32'(w) + (base - 32'h100);
    endfunction

    function automatic logic [63:0] beat_val(input logic [31:0] base, input int k);
        return {word_val(base, 2 * k + 1), word_val(base, 2 * k)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One fetch: drives the request, serves beats back-to-back while pmem_read is high,
    // pops the scoreboard on every response and checks the miss/latency profile.
    task automatic run_req(input logic [31:0] addr, input bit exp_miss, input bit hold);
        logic [31:0] base;
        logic [31:0] exp_word;
        int beat_idx;
        int cyc;
        int exp_lat;
        bit got;
        bit done;
        base = addr & ~32'h1F;
        beat_idx = 0;
        cyc = 0;
        got = 0;
        done = 0;
        seen_miss = 0;
        miss_addr = '0;
        lat = 0;
        resp_count = 0;
        pread_dropped = 0;
`ifdef ILINE_EARLY_RESP_EN
        exp_lat = exp_miss ? (32'(addr[4:3]) + 2) : 1;
`else
        exp_lat = exp_miss ? 5 : 1;
`endif
        @(posedge clk); #1;
        i_mem_read = 1'b1;
        i_mem_address = addr;
        exp_q.push_back(word_val(base, 32'(addr[4:2])));
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (beat_idx > 0 && beat_idx < 4 && !pmem_read) pread_dropped = 1;
            if (pmem_read && !seen_miss) begin
                seen_miss = 1;
                miss_addr = pmem_address;
            end
            if (pmem_read && beat_idx < 4) begin
                pmem_resp = 1'b1;
                pmem_rdata = beat_val(base, beat_idx);
                beat_idx++;
            end else begin
                pmem_resp = 1'b0;
                pmem_rdata = '0;
            end
            if (i_mem_resp) begin
                resp_count++;
                if (!got) begin
                    lat = cyc;
                    resp_cycle = cycle_cnt;
                end
                got = 1;
                if (exp_q.size() > 0) begin
                    exp_word = exp_q.pop_front();
                    check($sformatf("rdata@%0h", addr), i_mem_rdata, exp_word);
                end
                if (!hold) i_mem_read = 1'b0;
            end
            if (got && !pmem_read) done = 1;
        end
        pmem_resp = 1'b0;
        i_mem_read = 1'b0;
        check($sformatf("done@%0h", addr), done, 1);
        check($sformatf("miss@%0h", addr), seen_miss, exp_miss);
        if (exp_miss) begin
            check($sformatf("pmem_addr@%0h", addr), miss_addr, base);
            check($sformatf("beats@%0h", addr), beat_idx, 4);
            check($sformatf("pread_held@%0h", addr), pread_dropped, 0);
        end
        check($sformatf("latency@%0h", addr), lat, exp_lat);
        check($sformatf("resp_count@%0h", addr), resp_count, 1);
        $display("[TB] req %08h miss=%0d lat=%0d rdata=%08h", addr, seen_miss, lat, i_mem_rdata);
    endtask

    initial begin
        int t_first;

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp", i_mem_resp, 0);
        check("rst_rdata", i_mem_rdata, 0);
        check("rst_pread", pmem_read, 0);
        check("rst_paddr", pmem_address, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Request 0x100, deliver two beats, then reset in the middle of the fill
        @(posedge clk); #1;
        i_mem_read = 1'b1;
        i_mem_address = 32'h100;
        @(posedge clk); #1;
        check("midfill_pread", pmem_read, 1);
        check("midfill_paddr", pmem_address, 32'h100);
        pmem_resp = 1'b1;
        pmem_rdata = beat_val(32'h100, 0);
        @(posedge clk); #1;
        check("midfill_noresp0", i_mem_resp, 0);
        pmem_rdata = beat_val(32'h100, 1);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        i_mem_read = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_pread", pmem_read, 0);
        check("midrst_paddr", pmem_address, 0);
        check("midrst_resp", i_mem_resp, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("postrst_resp", i_mem_resp, 0);
        $display("[TB] reset mid-fill after 2 beats");

        // Same line again: partial fill must not count, so a full refill is expected
        run_req(32'h10C, 1, 0);

        // Stray beat outside a fill is ignored
        @(posedge clk); #1;
        pmem_resp = 1'b1;
        pmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        check("stray_pread", pmem_read, 0);
        check("stray_resp", i_mem_resp, 0);
        $display("[TB] stray pmem_resp in IDLE");

        // Hits, including back-to-back throughput
        run_req(32'h104, 0, 0);
        run_req(32'h118, 0, 0);
        t_first = resp_cycle;
        run_req(32'h11C, 0, 0);
        check("hit_interval", resp_cycle - t_first, 2);
        run_req(32'h100, 0, 0);

        // Replacement of the single line
        run_req(32'h120, 1, 0);
        run_req(32'h134, 0, 0);
        run_req(32'h100, 1, 0);

`ifdef ILINE_EARLY_RESP_EN
        // Request held through the remaining beats: still exactly one response
        run_req(32'h124, 1, 1);
        run_req(32'h12C, 0, 0);
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
